// File: rtl/vga_line_scanout.sv
// Ping-pong line buffer fed by the pixel remover, replayed under a free-running VGA raster.
// Display outputs are registered one cycle behind the raster counters to cover the RAM read.
module vga_line_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HSYNC,
    input  logic [7:0] data,
    input  logic       clr_status,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_DE,
    output logic [7:0] VGA_pixel,
    output logic       overflow,
    output logic       underrun
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned AW       = $clog2(H_ACTIVE);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          wbank_q, wbank_d;
    logic          rbank_q, rbank_d;
    logic [1:0]    full_q, full_d;
    logic          play_q, play_d;
    logic          overflow_q, overflow_d;
    logic          underrun_q, underrun_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic [7:0]    pix_q, pix_d;

    logic [7:0]    mem_q [0:1][0:H_ACTIVE-1];
    logic          mem_we;
    logic [7:0]    rd_data;
    logic [31:0]   h32, v32;
    logic          active, line_start, line_end, play;
    logic          ovf_set, unr_set;

    assign h32     = 32'(hcnt_q);
    assign v32     = 32'(vcnt_q);
    assign rd_data = mem_q[rbank_q][hcnt_q[AW-1:0]];

    always_comb begin
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        waddr_d    = waddr_q;
        wbank_d    = wbank_q;
        rbank_d    = rbank_q;
        full_d     = full_q;
        play_d     = play_q;
        mem_we     = 1'b0;
        ovf_set    = 1'b0;
        unr_set    = 1'b0;

        active     = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
        line_start = (hcnt_q == '0) && (v32 < V_ACTIVE);
        play       = line_start ? full_q[rbank_q] : play_q;
        line_end   = (h32 == H_ACTIVE - 1) && active && play;

        if (h32 == H_TOTAL - 1) begin
            hcnt_d = '0;
            vcnt_d = (v32 == V_TOTAL - 1) ? '0 : vcnt_q + VW'(1);
        end else begin
            hcnt_d = hcnt_q + HW'(1);
        end

        if (line_start) begin
            play_d  = full_q[rbank_q];
            unr_set = ~full_q[rbank_q];
        end

        // Reader clears only the full bank it owns, writer sets only a non-full bank,
        // so both updates can land in the same cycle without conflict.
        if (line_end) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
        end

        if (HSYNC) begin
            if (!full_q[wbank_q]) begin
                mem_we = 1'b1;
                if (waddr_q == AW'(H_ACTIVE - 1)) begin
                    full_d[wbank_q] = 1'b1;
                    wbank_d         = ~wbank_q;
                    waddr_d         = '0;
                end else begin
                    waddr_d = waddr_q + AW'(1);
                end
            end else begin
                ovf_set = 1'b1;
            end
        end

        overflow_d = ovf_set | (overflow_q & ~clr_status);
        underrun_d = unr_set | (underrun_q & ~clr_status);

        de_d  = active;
        pix_d = (active && play) ? rd_data : '0;
        hs_d  = !((h32 >= HS_START) && (h32 < HS_END));
        vs_d  = !((v32 >= VS_START) && (v32 < VS_END));
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hcnt_q     <= '0;
            vcnt_q     <= VW'(V_ACTIVE);
            waddr_q    <= '0;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            full_q     <= '0;
            play_q     <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            de_q       <= 1'b0;
            pix_q      <= '0;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            waddr_q    <= waddr_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            full_q     <= full_d;
            play_q     <= play_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            de_q       <= de_d;
            pix_q      <= pix_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            mem_q[wbank_q][waddr_q] <= data;
        end
    end

    assign VGA_HS    = hs_q;
    assign VGA_VS    = vs_q;
    assign VGA_DE    = de_q;
    assign VGA_pixel = pix_q;
    assign overflow  = overflow_q;
    assign underrun  = underrun_q;

endmodule

// File: doc/vga_line_scanout.md
# vga_line_scanout

Downstream consumer of the pixel remover stage. Captures the remover's 8-bit pixel stream, qualified by `HSYNC`, into a two-bank ping-pong line buffer. Replays each buffered line under a free-running VGA raster timing generator, producing `VGA_HS`, `VGA_VS`, `VGA_DE` and `VGA_pixel` for the display port. Reports lost input bytes and starved output lines through sticky status flags.

## Interface
- `H_ACTIVE`, 640: active pixels per line, which is also the bank depth.
- `H_FP`, 16: horizontal front porch, in cycles.
- `H_SYNC`, 96: horizontal sync width, in cycles.
- `H_BP`, 48: horizontal back porch, in cycles.
- `V_ACTIVE`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `HCLK`  in  1  the single clock. One clock; all logic is on the rising edge of `HCLK`.
- `HRESET`  in  1  reset, asynchronous and active-high.
- `HSYNC`  in  1  input byte strobe from upstream; `data` is valid when this is 1.
- `data`  in  8  input pixel byte (the remover's `VGA_data`).
- `clr_status`  in  1  single-cycle pulse that clears `overflow` and `underrun`.
- `VGA_HS`  out  1  horizontal sync, active low.
- `VGA_VS`  out  1  vertical sync, active low.
- `VGA_DE`  out  1  display enable; 1 during active pixels.
- `VGA_pixel`  out  8  output pixel.
- `overflow`  out  1  sticky flag: an input byte was dropped.
- `underrun`  out  1  sticky flag: an active line was blanked.

## Operation
- **Derived constants:** H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- **Counter widths:** `hcnt` is clog2(H_TOTAL) bits, `vcnt` is clog2(V_TOTAL) bits, `waddr` is clog2(H_ACTIVE) bits.
- **Storage:** two banks of H_ACTIVE×8 bits. Each bank has a registered `full` flag. Pointers `wbank` and `rbank` are each 1 bit.
- **Write side**, in any cycle with `HSYNC`=1:
  - If `full[wbank]`=0: write `data` to `mem[wbank][waddr]`.
  - If `waddr`=H_ACTIVE-1: set `full[wbank]`, toggle `wbank`, set `waddr`=0. Otherwise increment `waddr`.
  - If `full[wbank]`=1: drop the byte, hold `waddr`, set `overflow`.
- **Raster counters:**
  - `hcnt` counts 0..H_TOTAL-1 and wraps to 0.
  - On the wrap, `vcnt` increments; it wraps from V_TOTAL-1 to 0.
  - A cycle is active when `hcnt`<H_ACTIVE and `vcnt`<V_ACTIVE.
- **Line start** (`hcnt`=0, `vcnt`<V_ACTIVE):
  - `play` = `full[rbank]`. This value is used combinationally in that same cycle and registered as `play_q` for the rest of the line.
  - If `full[rbank]`=0: set `underrun`.
- **Read:** every active cycle reads `mem[rbank][hcnt]`.
- **Line end** (`hcnt`=H_ACTIVE-1, active, `play_q`=1):
  - Clear `full[rbank]` and toggle `rbank`.
  - An unplayed line never toggles `rbank`.
- **Bank exclusivity:** the writer only writes a non-full bank and the reader only reads a full bank, so the two sides never touch the same bank. Set and clear of different banks in the same cycle both take effect.
- **Release visibility:** a `full` clear becomes visible to the writer one cycle later. A byte arriving in the release cycle for that bank is dropped and flagged.
- **Status flags:** on `clr_status`, both flags go to 0. If a set condition occurs in the same cycle, set wins.
- **Reset (async, also mid-frame):**
  - Counters: `hcnt`=0, `vcnt`=V_ACTIVE (the frame starts in front porch, which gives the writer lead time).
  - Buffer control: `waddr`=0, `wbank`=`rbank`=0, both `full`=0, `play_q`=0. RAM contents are not cleared.
  - Outputs: `VGA_HS`=1, `VGA_VS`=1, `VGA_DE`=0, `VGA_pixel`=0, `overflow`=0, `underrun`=0.

## Timing
- **Registered outputs:** all display outputs are registered with 1-cycle latency from the counter state, covering the RAM read.
  - `VGA_DE`(t+1) = active(t).
  - `VGA_pixel`(t+1) = mem data if active(t) and play, else 0.
  - `VGA_HS`(t+1) = 0 iff H_ACTIVE+H_FP ≤ `hcnt`(t) < H_ACTIVE+H_FP+H_SYNC.
  - `VGA_VS`(t+1) = 0 iff V_ACTIVE+V_FP ≤ `vcnt`(t) < V_ACTIVE+V_FP+V_SYNC.
- **Write path:** a byte written at cycle t is readable from cycle t+1. A line whose last byte is written in the cycle its line-start check occurs is not played.
- **Input rate:** the writer accepts one byte per cycle with no backpressure.
- **Status latency:** `overflow` and `underrun` assert 1 cycle after the causing event.

## Test plan
All scenarios use H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8) and V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=5).
- **Async reset:** assert `HRESET` mid-line → `VGA_HS`=1, `VGA_VS`=1, `VGA_DE`=0, `VGA_pixel`=0, flags 0, without waiting for a clock edge. First `VGA_VS` low is at cycle 8 after release, lasting 8 cycles.
- **Raster timing:** run free → `VGA_HS` is low 2 of every 8 cycles at `hcnt` 5–6 (+1 latency). `VGA_DE` is high for 4 cycles on 2 lines of every 5.
- **Replay:** after reset, strobe 0x11, 0x22, 0x33, 0x44, then 0xA1..0xA4 → first active line shows `VGA_pixel` 0x11, 0x22, 0x33, 0x44 with `VGA_DE`=1. The second line shows 0xA1..0xA4. `underrun` stays 0.
- **Underrun:** no input after reset → each active line has `VGA_DE`=1 with `VGA_pixel`=0. `underrun`=1 from the first line start +1. `rbank` does not toggle.
- **Overflow:** strobe 12 bytes 0x01..0x0C on consecutive cycles from reset release → bytes 0x09..0x0C are dropped and `overflow`=1. The lines replay 0x01–0x04, then 0x05–0x08.
- **Status clear:** pulse `clr_status` with no event pending → both flags go to 0. Pulse it in the same cycle as a dropped byte → `overflow` stays 1.
